fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of one `fifo` instance among N requesters.
- Each requester has a valid/ready/data/last interface.
- The arbiter selects one owner, muxes that owner's data onto the FIFO write port, and respects the FIFO's `full` flag.
- With packet lock enabled, an owner keeps the port until it transfers a beat marked last.
- Sits between producer blocks (UART RX, SPI, DMA) and a shared ingress FIFO.

Parameters:
- N, 4, number of requesters; minimum 2, need not be a power of two.
- WIDTH, 8, data width of each requester and of the FIFO write port.
- LOCK, "none", "none" = release after every accepted beat; "packet" = release only after an accepted beat with last=1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- req_valid  in  N  per-requester beat valid; once asserted, must be held until that beat is accepted.
- req_data  in  N*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  N  per-requester end-of-packet flag; ignored when LOCK="none".
- req_ready  out  N  per-requester accept; at most one bit set.
- fifo_din  out  WIDTH  data to the FIFO din.
- fifo_w  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag.
- grant_id  out  clog2(N)  registered index of the current owner.
- busy  out  1  high while a requester owns the port.

Behaviour:
- States: IDLE, GRANT. State, owner and rr pointer `ptr` (clog2(N) bits) are flops with async clear on rstn low.
- Reset values:
  - state=IDLE, ptr=0, grant_id=0, busy=0.
  - req_ready=0, fifo_w=0, fifo_din=0. These are combinational but gated by state, so they are 0 immediately on rstn low.
- IDLE:
  - If any req_valid is set, select the first set index scanning ptr, ptr+1, ..., wrapping modulo N (not modulo 2^bits).
  - Register the selection into grant_id and go to GRANT on the next edge.
  - If no req_valid is set, stay in IDLE and keep ptr unchanged.
  - No transfer happens in the arbitration cycle. Minimum latency from valid to write is 1 cycle.
- GRANT, combinational outputs:
  - req_ready[grant_id] = ~fifo_full; all other req_ready bits are 0.
  - fifo_w = req_valid[grant_id] & ~fifo_full.
  - fifo_din = req_data[grant_id] whenever busy; 0 in IDLE.
- A beat is accepted on any clock edge where fifo_w=1.
- Release, LOCK="none": on an accepted beat, next state=IDLE and ptr=(grant_id+1) mod N.
- Release, LOCK="packet": on an accepted beat with req_last[grant_id]=1, next state=IDLE and ptr=(grant_id+1) mod N.
  - Accepted beats with last=0 keep GRANT.
  - If the owner drops valid between beats, GRANT is held indefinitely; there is no timeout.
- fifo_full high in GRANT: no write, no ready, owner retained; writing resumes on the first cycle full is low.
- Requests from non-owners never affect the current grant. They are considered only at the next IDLE.
- Fairness: a requester that is continuously valid is granted within N arbitrations.
- busy = (state==GRANT).
- Reset mid-operation: state returns to IDLE immediately; any partial packet is abandoned (the FIFO's own reset or clear handles its contents). On release, arbitration restarts from ptr=0.
- No X propagation: grant_id is always < N.

Test Plan:
1. N=4, LOCK="none": req_valid=4'b0010 with data[1]=0xA5, fifo_full=0 → cycle 0 IDLE; cycle 1 busy=1, grant_id=1, req_ready=4'b0010, fifo_w=1, fifo_din=0xA5; cycle 2 IDLE with ptr=2.
2. N=4, LOCK="none": all req_valid held high with data i=0x10+i → write sequence 0x10,0x11,0x12,0x13,0x10, one write every 2 cycles, grant_id 0,1,2,3,0.
3. Requester 2 owns the port with fifo_full=1 for 5 cycles → fifo_w=0 and req_ready=0 throughout, grant_id=2 held. Full drops → exactly one write of the held data, no duplicate or lost beat.
4. LOCK="packet", N=4: req0 sends beats 0x10, 0x11, 0x12 (last on 0x12) with a 2-cycle valid gap before 0x11; req2 is pending throughout → FIFO receives 0x10,0x11,0x12 then req2's beat. req_ready[2] stays 0 until the packet ends.
5. Wrap, N=3: ptr=2, req_valid=3'b001 → grant_id=0 next cycle. Then ptr=1 with 3'b101 → grant_id=2.
6. rstn pulsed low for 1 cycle mid-packet, asynchronous to clk → busy, fifo_w and req_ready are 0 within the same cycle. After release the first grant goes to the lowest-index valid requester (ptr=0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready requesters.
// Optional packet lock keeps the owner until it writes a beat marked last.
module fifo_wr_arbiter #(
  parameter int    N     = 4,
  parameter int    WIDTH = 8,
  parameter string LOCK  = "none"
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N-1:0]          req_valid,
  input  logic [N*WIDTH-1:0]    req_data,
  input  logic [N-1:0]          req_last,
  output logic [N-1:0]          req_ready,
  output logic [WIDTH-1:0]      fifo_din,
  output logic                  fifo_w,
  input  logic                  fifo_full,
  output logic [$clog2(N)-1:0]  grant_id,
  output logic                  busy
);

  localparam int IW     = $clog2(N);
  localparam bit PACKET = (LOCK == "packet");

  // Handshake: a beat moves on every clock edge where req_valid and req_ready of
  // the owner are both high, which is exactly when fifo_w is high. A requester
  // holds valid and data stable until its beat is accepted.

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_d;
  logic [IW-1:0]   grant_inc;
  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  logic [IW:0]     scan_sum;
  logic [IW-1:0]   scan_idx;
  logic [WIDTH-1:0] data_arr [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // First valid requester at or after ptr; the wrap is modulo N, not 2^IW.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N)) begin
        scan_sum = scan_sum - (IW+1)'(N);
      end
      scan_idx = scan_sum[IW-1:0];
      if (!sel_found && req_valid[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign grant_inc = (grant_id == IW'(N-1)) ? '0 : grant_id + IW'(1);
  assign busy      = (state_q == GRANT);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_id;
    req_ready = '0;
    fifo_w    = 1'b0;
    fifo_din  = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id] = ~fifo_full;
        fifo_w              = req_valid[grant_id] & ~fifo_full;
        fifo_din            = data_arr[grant_id];
        if (fifo_w && (!PACKET || req_last[grant_id])) begin
          state_d = IDLE;
          ptr_d   = grant_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_id <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_id <= grant_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: three instances (N=4 none, N=4 packet, N=3 none),
// write data checked against per-instance expected queues.
module tb_fifo_wr_arbiter;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, LOCK none
  logic [3:0]  a_valid, a_last, a_ready;
  logic [31:0] a_data;
  logic [7:0]  a_din;
  logic        a_w, a_full, a_busy;
  logic [1:0]  a_gid;
  // Instance B: N=4, LOCK packet
  logic [3:0]  b_valid, b_last, b_ready;
  logic [31:0] b_data;
  logic [7:0]  b_din;
  logic        b_w, b_full, b_busy;
  logic [1:0]  b_gid;
  // Instance C: N=3, LOCK none
  logic [2:0]  c_valid, c_last, c_ready;
  logic [23:0] c_data;
  logic [7:0]  c_din;
  logic        c_w, c_full, c_busy;
  logic [1:0]  c_gid;

  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  logic [7:0] c_q[$];
  logic [7:0] a_e, b_e, c_e;

  fifo_wr_arbiter #(.N(4), .WIDTH(8), .LOCK("none")) u_a (
    .clk(clk), .rstn(rstn), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
    .req_ready(a_ready), .fifo_din(a_din), .fifo_w(a_w), .fifo_full(a_full),
    .grant_id(a_gid), .busy(a_busy));

  fifo_wr_arbiter #(.N(4), .WIDTH(8), .LOCK("packet")) u_b (
    .clk(clk), .rstn(rstn), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
    .req_ready(b_ready), .fifo_din(b_din), .fifo_w(b_w), .fifo_full(b_full),
    .grant_id(b_gid), .busy(b_busy));

  fifo_wr_arbiter #(.N(3), .WIDTH(8), .LOCK("none")) u_c (
    .clk(clk), .rstn(rstn), .req_valid(c_valid), .req_data(c_data), .req_last(c_last),
    .req_ready(c_ready), .fifo_din(c_din), .fifo_w(c_w), .fifo_full(c_full),
    .grant_id(c_gid), .busy(c_busy));

  // Scoreboards: every FIFO write must match the oldest expected beat.
  always @(negedge clk) begin
    if (a_w === 1'b1) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++; $display("FAIL a_write unexpected din=%h", a_din);
      end else begin
        a_e = a_q.pop_front();
        if (a_din !== a_e) begin errors++; $display("FAIL a_write got %h exp %h", a_din, a_e); end
      end
    end
  end

  always @(negedge clk) begin
    if (b_w === 1'b1) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++; $display("FAIL b_write unexpected din=%h", b_din);
      end else begin
        b_e = b_q.pop_front();
        if (b_din !== b_e) begin errors++; $display("FAIL b_write got %h exp %h", b_din, b_e); end
      end
    end
  end

  always @(negedge clk) begin
    if (c_w === 1'b1) begin
      checks++;
      if (c_q.size() == 0) begin
        errors++; $display("FAIL c_write unexpected din=%h", c_din);
      end else begin
        c_e = c_q.pop_front();
        if (c_din !== c_e) begin errors++; $display("FAIL c_write got %h exp %h", c_din, c_e); end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_busy, a_w, a_gid, a_ready, a_din} !== 16'h0) begin
      errors++; $display("FAIL reset_a got %h exp 0", {a_busy, a_w, a_gid, a_ready, a_din});
    end
    checks++;
    if ({b_busy, b_w, b_gid, b_ready, b_din} !== 16'h0) begin
      errors++; $display("FAIL reset_b got %h exp 0", {b_busy, b_w, b_gid, b_ready, b_din});
    end
    checks++;
    if ({c_busy, c_w, c_gid, c_ready, c_din} !== 15'h0) begin
      errors++; $display("FAIL reset_c got %h exp 0", {c_busy, c_w, c_gid, c_ready, c_din});
    end
    tick;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_busy, a_w} !== 2'b00) begin
      errors++; $display("FAIL idle_no_req got %b exp 00", {a_busy, a_w});
    end
    tick;
  endtask

  task automatic test_single;
    a_valid = 4'b0010;
    a_data[15:8] = 8'hA5;
    a_q.push_back(8'hA5);
    @(negedge clk);
    checks++;
    if ({a_busy, a_w, a_ready} !== 6'b0) begin
      errors++; $display("FAIL single_arb got %b exp 0", {a_busy, a_w, a_ready});
    end
    tick;
    @(negedge clk);
    checks++;
    if ({a_busy, a_w, a_gid, a_ready, a_din} !== {1'b1, 1'b1, 2'd1, 4'b0010, 8'hA5}) begin
      errors++; $display("FAIL single_grant got %h exp %h", {a_busy, a_w, a_gid, a_ready, a_din},
                         {1'b1, 1'b1, 2'd1, 4'b0010, 8'hA5});
    end
    tick;
    a_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if ({a_busy, a_w} !== 2'b00) begin
      errors++; $display("FAIL single_release got %b exp 00", {a_busy, a_w});
    end
    // ptr now 2: with 0,1,3 requesting, 3 must win
    tick;
    a_valid = 4'b1011;
    a_data = {8'h33, 8'h22, 8'h11, 8'h00};
    a_q.push_back(8'h33);
    tick;
    @(negedge clk);
    checks++;
    if ({a_w, a_gid, a_ready} !== {1'b1, 2'd3, 4'b1000}) begin
      errors++; $display("FAIL single_ptr got %b exp %b", {a_w, a_gid, a_ready}, {1'b1, 2'd3, 4'b1000});
    end
    tick;
    a_valid = 4'b0000;
    tick;
  endtask

  task automatic test_round_robin;
    a_data = {8'h13, 8'h12, 8'h11, 8'h10};
    a_valid = 4'b1111;
    a_q.push_back(8'h10); a_q.push_back(8'h11); a_q.push_back(8'h12);
    a_q.push_back(8'h13); a_q.push_back(8'h10);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (c % 2 == 1) begin
        if ({a_w, a_gid} !== {1'b1, 2'((c / 2) % 4)}) begin
          errors++; $display("FAIL rr_cycle%0d got %b exp %b", c, {a_w, a_gid}, {1'b1, 2'((c / 2) % 4)});
        end
      end else begin
        if ({a_busy, a_w} !== 2'b00) begin
          errors++; $display("FAIL rr_idle%0d got %b exp 00", c, {a_busy, a_w});
        end
      end
      tick;
    end
    a_valid = 4'b0000;
    tick;
  endtask

  task automatic test_full_hold;
    a_full = 1'b1;
    a_valid = 4'b0100;
    a_data[23:16] = 8'h77;
    a_q.push_back(8'h77);
    tick;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({a_busy, a_w, a_gid, a_ready} !== {1'b1, 1'b0, 2'd2, 4'b0000}) begin
        errors++; $display("FAIL full_hold%0d got %b exp %b", c, {a_busy, a_w, a_gid, a_ready},
                           {1'b1, 1'b0, 2'd2, 4'b0000});
      end
      tick;
    end
    a_full = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_w, a_ready} !== {1'b1, 4'b0100}) begin
      errors++; $display("FAIL full_resume got %b exp %b", {a_w, a_ready}, {1'b1, 4'b0100});
    end
    tick;
    a_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if ({a_busy, a_w} !== 2'b00) begin
      errors++; $display("FAIL full_release got %b exp 00", {a_busy, a_w});
    end
    tick;
  endtask

  task automatic test_packet_lock;
    b_valid = 4'b0101;
    b_data[7:0] = 8'h10;
    b_data[23:16] = 8'h55;
    b_last = 4'b0100;
    b_q.push_back(8'h10); b_q.push_back(8'h11); b_q.push_back(8'h12); b_q.push_back(8'h55);
    tick;
    @(negedge clk);
    checks++;
    if ({b_w, b_gid, b_ready} !== {1'b1, 2'd0, 4'b0001}) begin
      errors++; $display("FAIL pkt_beat0 got %b exp %b", {b_w, b_gid, b_ready}, {1'b1, 2'd0, 4'b0001});
    end
    tick;
    b_valid[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({b_busy, b_w, b_gid, b_ready[2]} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
        errors++; $display("FAIL pkt_gap%0d got %b exp %b", c, {b_busy, b_w, b_gid, b_ready[2]},
                           {1'b1, 1'b0, 2'd0, 1'b0});
      end
      tick;
    end
    b_valid[0] = 1'b1;
    b_data[7:0] = 8'h11;
    @(negedge clk);
    checks++;
    if ({b_w, b_ready} !== {1'b1, 4'b0001}) begin
      errors++; $display("FAIL pkt_beat1 got %b exp %b", {b_w, b_ready}, {1'b1, 4'b0001});
    end
    tick;
    b_data[7:0] = 8'h12;
    b_last[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({b_w, b_ready} !== {1'b1, 4'b0001}) begin
      errors++; $display("FAIL pkt_beat2 got %b exp %b", {b_w, b_ready}, {1'b1, 4'b0001});
    end
    tick;
    b_valid[0] = 1'b0;
    b_last[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_busy, b_ready} !== 5'b0) begin
      errors++; $display("FAIL pkt_release got %b exp 0", {b_busy, b_ready});
    end
    tick;
    @(negedge clk);
    checks++;
    if ({b_w, b_gid, b_ready} !== {1'b1, 2'd2, 4'b0100}) begin
      errors++; $display("FAIL pkt_next got %b exp %b", {b_w, b_gid, b_ready}, {1'b1, 2'd2, 4'b0100});
    end
    tick;
    b_valid = 4'b0000;
    b_last = 4'b0000;
    tick;
  endtask

  task automatic test_wrap;
    c_valid = 3'b010;
    c_data = {8'h22, 8'h21, 8'h20};
    c_q.push_back(8'h21);
    tick;
    @(negedge clk);
    checks++;
    if ({c_w, c_gid} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL wrap_g1 got %b exp %b", {c_w, c_gid}, {1'b1, 2'd1});
    end
    tick;
    c_valid = 3'b001;
    c_q.push_back(8'h20);
    tick;
    @(negedge clk);
    checks++;
    if ({c_w, c_gid} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL wrap_g0 got %b exp %b", {c_w, c_gid}, {1'b1, 2'd0});
    end
    tick;
    c_valid = 3'b101;
    c_q.push_back(8'h22);
    tick;
    @(negedge clk);
    checks++;
    if ({c_w, c_gid} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL wrap_g2 got %b exp %b", {c_w, c_gid}, {1'b1, 2'd2});
    end
    tick;
    c_valid = 3'b001;
    c_q.push_back(8'h20);
    tick;
    @(negedge clk);
    checks++;
    if ({c_w, c_gid} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL wrap_back0 got %b exp %b", {c_w, c_gid}, {1'b1, 2'd0});
    end
    tick;
    c_valid = 3'b000;
    tick;
  endtask

  task automatic test_async_reset;
    b_valid = 4'b0010;
    b_data[15:8] = 8'h41;
    b_last = 4'b0000;
    b_q.push_back(8'h41);
    tick;
    @(negedge clk);
    checks++;
    if ({b_w, b_gid} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL areset_pre got %b exp %b", {b_w, b_gid}, {1'b1, 2'd1});
    end
    tick;
    b_data[15:8] = 8'h42;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({b_busy, b_w, b_ready, b_gid} !== 8'h0) begin
      errors++; $display("FAIL areset_now got %b exp 0", {b_busy, b_w, b_ready, b_gid});
    end
    @(posedge clk);
    #3 rstn = 1'b1;
    b_valid = 4'b1010;
    b_data[15:8] = 8'h43;
    b_data[31:24] = 8'h63;
    b_last = 4'b1010;
    b_q.push_back(8'h43); b_q.push_back(8'h63);
    @(negedge clk);
    checks++;
    if ({b_busy, b_w} !== 2'b00) begin
      errors++; $display("FAIL areset_idle got %b exp 00", {b_busy, b_w});
    end
    tick;
    @(negedge clk);
    checks++;
    if ({b_w, b_gid} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL areset_ptr0 got %b exp %b", {b_w, b_gid}, {1'b1, 2'd1});
    end
    tick;
    b_valid[1] = 1'b0;
    tick;
    @(negedge clk);
    checks++;
    if ({b_w, b_gid} !== {1'b1, 2'd3}) begin
      errors++; $display("FAIL areset_next got %b exp %b", {b_w, b_gid}, {1'b1, 2'd3});
    end
    tick;
    b_valid = 4'b0000;
    b_last = 4'b0000;
    repeat (2) tick;
  endtask

  task automatic test_drain;
    checks++;
    if (a_q.size() != 0) begin errors++; $display("FAIL a_drain got %0d exp 0", a_q.size()); end
    checks++;
    if (b_q.size() != 0) begin errors++; $display("FAIL b_drain got %0d exp 0", b_q.size()); end
    checks++;
    if (c_q.size() != 0) begin errors++; $display("FAIL c_drain got %0d exp 0", c_q.size()); end
  endtask

  initial begin
    rstn = 1'b0;
    a_valid = '0; a_last = '0; a_data = '0; a_full = 1'b0;
    b_valid = '0; b_last = '0; b_data = '0; b_full = 1'b0;
    c_valid = '0; c_last = '0; c_data = '0; c_full = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_full_hold;
    test_packet_lock;
    test_wrap;
    test_async_reset;
    test_drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
